tagged_stream_arbiter: RTL and testbench
========================================

// Module: tagged_stream_arbiter
// PURPOSE
// Round-robin arbiter that merges NUM_INPUTS data streams onto one output stream and tags each beat with its source index.
// A grant is held for a whole stream, from the first beat through the beat with last=1, so streams never interleave.
// Its output feeds the tagged_i fabric consumed by the tagged multiplexers; it is the requester-side scheduler for that crossbar.
// PARAMETERS
// NUM_INPUTS   4    number of requesting input streams (>=2)
// DATA_WIDTH   64   payload width in bits
// TAG_WIDTH    2    tag width; must satisfy 2**TAG_WIDTH >= NUM_INPUTS
// FILTER_KEEP  1    1: drop beats with keep=0 (consume, never output, except a keep=0 last beat, forwarded to close the stream); 0: forward all
// PORTS
// clk        in   1                       clock
// rst_n      in   1                       synchronous active-low reset
// in_data    in   NUM_INPUTS*DATA_WIDTH   input payload, input i at [i*DATA_WIDTH +: DATA_WIDTH]
// in_keep    in   NUM_INPUTS              per-input keep
// in_last    in   NUM_INPUTS              per-input end-of-stream marker
// in_valid   in   NUM_INPUTS              per-input valid
// in_ready   out  NUM_INPUTS              per-input ready
// out_data   out  DATA_WIDTH              granted payload
// out_tag    out  TAG_WIDTH               index of source input
// out_keep   out  1                       keep of forwarded beat
// out_last   out  1                       last of forwarded beat
// out_valid  out  1                       output valid
// out_ready  in   1                       downstream ready
// BEHAVIOUR
// - Reset (rst_n=0 at posedge): state=IDLE, rr_ptr=0, out_valid=0, out_keep=0, out_last=0, in_ready=0; data/tag don't-care.
// - Output register: single stage, loads when load_en = !out_valid || out_ready; full throughput; latency 1 cycle in->out.
// - in_ready[i] = load_en && (i == current selection); all other in_ready = 0. Transfer on a port = valid && ready.
// - State IDLE: selection = first i with in_valid[i]=1 scanning rr_ptr, rr_ptr+1, ... wrapping modulo NUM_INPUTS.
//   On transfer of a beat from i: if in_last[i]=1 -> stay IDLE, rr_ptr <= (i+1) mod NUM_INPUTS; else -> LOCKED, owner <= i.
//   No valid input: in_ready=0, nothing loaded.
// - State LOCKED: selection = owner only; others stalled even if valid.
//   On transfer with in_last[owner]=1 -> IDLE, rr_ptr <= (owner+1) mod NUM_INPUTS.
// - Grant may change only on a last transfer; an owner dropping valid mid-stream holds LOCKED indefinitely (no timeout).
// - FILTER_KEEP=1: a keep=0, last=0 beat is consumed (in_ready=1 whenever load_en) but not loaded; out_valid drops to 0 that
//   cycle if the register was drained. keep=0, last=1 beats are loaded so out_last is delivered; state transitions still occur.
// - Loaded beat: out_data=in_data[sel], out_tag=sel zero-extended, out_keep, out_last copied; out_valid=1.
// - Backpressure: while out_valid && !out_ready, output fields hold stable, all in_ready=0, state/rr_ptr frozen.
// - Simultaneous valid on all inputs in IDLE: strict rotation from rr_ptr; each input gets one stream per round.
// - Reset mid-stream: state returns to IDLE, out_valid=0 next cycle; the partially forwarded stream is not closed (upstream
//   and downstream must also be reset).
// - Assertions: out fields stable under backpressure; at most one in_ready high; out_tag < NUM_INPUTS;
//   no tag change between a non-last beat and the next output beat.
// TESTING
// 1 Reset: hold rst_n=0 3 cycles with all in_valid=1 -> out_valid=0, in_ready=0; first beat after release from input 0, tag=0.
// 2 Round robin: all 4 inputs valid, single-beat streams (last=1) -> out_tag sequence 0,1,2,3,0,1 one per cycle, out_ready=1.
// 3 Lock: input 1 sends 5-beat stream while input 0 is valid -> tags 1,1,1,1,1 then 2 or 0 by rr; no interleave.
// 4 Backpressure: out_ready toggled 1,0,0,1 mid-stream -> out_data/tag held during 0s, no beat lost or duplicated, order kept.
// 5 Filter: FILTER_KEEP=1, input 2 stream keep=1,0,1, last on third -> 2 output beats with tag=2, second has last=1.
//   Filter close: stream keep=1,0 with last on the keep=0 beat -> 2 output beats, second has out_keep=0, out_last=1.
// 6 Random: 10k cycles, random valid/ready/last on 4 inputs -> scoreboard per-tag streams match input order exactly.

Source files
------------

// File: rtl/tagged_stream_arbiter.sv
// Round-robin merge of NUM_INPUTS streams onto one tagged output stream.
// A grant is held from the first beat of a stream through its last beat, so streams never interleave.
module tagged_stream_arbiter #(
  parameter int NUM_INPUTS  = 4,
  parameter int DATA_WIDTH  = 64,
  parameter int TAG_WIDTH   = 2,
  parameter int FILTER_KEEP = 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_INPUTS-1:0]            in_keep,
  input  logic [NUM_INPUTS-1:0]            in_last,
  input  logic [NUM_INPUTS-1:0]            in_valid,
  output logic [NUM_INPUTS-1:0]            in_ready,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic [TAG_WIDTH-1:0]             out_tag,
  output logic                             out_keep,
  output logic                             out_last,
  output logic                             out_valid,
  input  logic                             out_ready
);

  localparam int IDX_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;

  logic [0:0]       state;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] owner;
  logic [IDX_W-1:0] sel;
  logic [IDX_W-1:0] sel_next;
  logic [IDX_W-1:0] cand;
  logic             sel_active;
  logic             load_en;
  logic             xfer;
  logic             sel_keep;
  logic             sel_last;
  logic             load_beat;

  assign load_en = !out_valid || out_ready;

  // Scan from the highest offset down so the candidate closest to rr_ptr wins.
  always_comb begin
    sel        = owner;
    sel_active = (state == LOCKED);
    cand       = '0;
    if (state == IDLE) begin
      for (int k = NUM_INPUTS - 1; k >= 0; k--) begin
        cand = IDX_W'((int'(rr_ptr) + k) % NUM_INPUTS);
        if (in_valid[cand]) begin
          sel        = cand;
          sel_active = 1'b1;
        end
      end
    end
  end

  always_comb begin
    in_ready = '0;
    if (rst_n && load_en && sel_active) begin
      in_ready[sel] = 1'b1;
    end
  end

  assign sel_keep  = in_keep[sel];
  assign sel_last  = in_last[sel];
  assign xfer      = rst_n && load_en && sel_active && in_valid[sel];
  assign load_beat = xfer && ((FILTER_KEEP == 0) || sel_keep || sel_last);
  assign sel_next  = (sel == IDX_W'(NUM_INPUTS - 1)) ? '0 : sel + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      owner     <= '0;
      out_valid <= 1'b0;
      out_keep  <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      if (load_en) begin
        out_valid <= load_beat;
        if (load_beat) begin
          out_keep <= sel_keep;
          out_last <= sel_last;
        end
      end
      if (xfer) begin
        if (sel_last) begin
          state  <= IDLE;
          rr_ptr <= sel_next;
        end else begin
          state <= LOCKED;
          owner <= sel;
        end
      end
    end
  end

  // Payload and tag carry no reset; they are qualified by out_valid.
  always_ff @(posedge clk) begin
    if (load_beat) begin
      out_data <= in_data[int'(sel)*DATA_WIDTH +: DATA_WIDTH];
      out_tag  <= TAG_WIDTH'(sel);
    end
  end

  a_hold_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid && !out_ready) |=> (out_valid && $stable(out_data) && $stable(out_tag)
                                   && $stable(out_keep) && $stable(out_last)));

  a_one_ready: assert property (@(posedge clk) $onehot0(in_ready));

  a_tag_range: assert property (@(posedge clk) disable iff (!rst_n)
    out_valid |-> (int'(out_tag) < NUM_INPUTS));

  // An open (non-last) output beat implies the grant is still held by that same source.
  a_no_interleave: assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid && !out_last) |-> (state == LOCKED && int'(out_tag) == int'(owner)));

endmodule

// File: tb/tb_tagged_stream_arbiter.sv
// Directed and random checks of tagged_stream_arbiter against a per-source scoreboard.
// Beats accepted on an input are queued as expected output and matched by tag when they emerge.
module tb_tagged_stream_arbiter;

  localparam int N  = 4;
  localparam int DW = 64;
  localparam int TW = 2;

  typedef struct {
    logic [TW-1:0] tag;
    logic [DW-1:0] data;
    logic          keep;
    logic          last;
  } beat_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N*DW-1:0] in_data = '0;
  logic [N-1:0]    in_keep = '0;
  logic [N-1:0]    in_last = '0;
  logic [N-1:0]    in_valid = '0;
  logic [N-1:0]    in_ready;
  logic [DW-1:0]   out_data;
  logic [TW-1:0]   out_tag;
  logic            out_keep;
  logic            out_last;
  logic            out_valid;
  logic            out_ready = 1'b0;

  beat_t src_q [N][$];
  beat_t exp_q [$];
  beat_t obs_q [$];

  logic [N-1:0]    valid_en = '1;
  logic            rdy = 1'b1;
  int              total = 0;
  int              bad = 0;

  logic            held_v = 1'b0;
  logic [DW-1:0]   held_data;
  logic [TW-1:0]   held_tag;
  logic            open_v = 1'b0;
  logic [TW-1:0]   open_tag;

  logic [TW-1:0]   exp_rr [8] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
  logic [TW-1:0]   exp_lock [6] = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd0};
  logic            rdy_pat [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
  logic [DW-1:0]   bp_data [4];

  tagged_stream_arbiter #(
    .NUM_INPUTS(N), .DATA_WIDTH(DW), .TAG_WIDTH(TW), .FILTER_KEEP(1)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_keep(in_keep), .in_last(in_last),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_tag(out_tag), .out_keep(out_keep),
    .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] observed, input logic [63:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", name, observed, expected);
    end
  endtask

  task automatic pushBeat(input int i, input logic [DW-1:0] d, input logic k, input logic l);
    beat_t b;
    b.tag  = TW'(i);
    b.data = d;
    b.keep = k;
    b.last = l;
    src_q[i].push_back(b);
  endtask

  function automatic bit busy();
    busy = (exp_q.size() > 0);
    for (int i = 0; i < N; i++) if (src_q[i].size() > 0) busy = 1'b1;
  endfunction

  // Mid-cycle sampling: output beats are scored first, then this cycle's input handshakes are queued.
  task automatic monitorCycle();
    beat_t b;
    bit    found;
    if (held_v) begin
      checkOutput("hold_valid", 64'(out_valid), 64'(1));
      checkOutput("hold_data", out_data, held_data);
      checkOutput("hold_tag", 64'(out_tag), 64'(held_tag));
    end
    held_v = 1'b0;
    if (out_valid === 1'b1 && out_ready) begin
      found = 1'b0;
      for (int k = 0; k < exp_q.size(); k++) begin
        if (exp_q[k].tag == out_tag) begin
          checkOutput("out_data", out_data, exp_q[k].data);
          checkOutput("out_keep", 64'(out_keep), 64'(exp_q[k].keep));
          checkOutput("out_last", 64'(out_last), 64'(exp_q[k].last));
          exp_q.delete(k);
          found = 1'b1;
          break;
        end
      end
      checkOutput("beat_expected", 64'(found), 64'(1));
      if (open_v) checkOutput("no_interleave", 64'(out_tag), 64'(open_tag));
      open_v   = !out_last;
      open_tag = out_tag;
      b.tag = out_tag; b.data = out_data; b.keep = out_keep; b.last = out_last;
      obs_q.push_back(b);
    end else if (out_valid === 1'b1) begin
      held_v    = 1'b1;
      held_data = out_data;
      held_tag  = out_tag;
      checkOutput("stall_in_ready", 64'(in_ready), 64'(0));
    end
    for (int i = 0; i < N; i++) begin
      if (in_valid[i] && in_ready[i] === 1'b1 && src_q[i].size() > 0) begin
        b = src_q[i].pop_front();
        if (b.keep || b.last) exp_q.push_back(b);
      end
    end
  endtask

  task automatic applyStimulus();
    for (int i = 0; i < N; i++) begin
      if (src_q[i].size() > 0 && valid_en[i]) begin
        in_valid[i]          = 1'b1;
        in_data[i*DW +: DW]  = src_q[i][0].data;
        in_keep[i]           = src_q[i][0].keep;
        in_last[i]           = src_q[i][0].last;
      end else begin
        in_valid[i] = 1'b0;
        in_keep[i]  = 1'b0;
        in_last[i]  = 1'b0;
      end
    end
    out_ready = rdy;
    @(negedge clk);
    monitorCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic runUntilIdle(input int max_cycles);
    int c;
    c = 0;
    valid_en = '1;
    rdy = 1'b1;
    while (busy() && c < max_cycles) begin
      applyStimulus();
      c++;
    end
    checkOutput("drain_done", 64'(busy()), 64'(0));
  endtask

  initial begin
    @(posedge clk);
    #1;

    $display("[TB] reset with all inputs valid, then round robin");
    for (int i = 0; i < N; i++) begin
      pushBeat(i, {$urandom, $urandom}, 1'b1, 1'b1);
      pushBeat(i, {$urandom, $urandom}, 1'b1, 1'b1);
    end
    rst_n = 1'b0;
    for (int c = 0; c < 3; c++) begin
      applyStimulus();
      checkOutput("rst_out_valid", 64'(out_valid), 64'(0));
      checkOutput("rst_in_ready", 64'(in_ready), 64'(0));
    end
    checkOutput("rst_out_keep", 64'(out_keep), 64'(0));
    checkOutput("rst_out_last", 64'(out_last), 64'(0));
    rst_n = 1'b1;
    #1;
    checkOutput("first_ready", 64'(in_ready), 64'(4'b0001));
    obs_q.delete();
    for (int c = 0; c < 9; c++) applyStimulus();
    checkOutput("rr_count", 64'(obs_q.size()), 64'(8));
    for (int j = 0; j < 8; j++)
      if (j < obs_q.size()) checkOutput("rr_tag", 64'(obs_q[j].tag), 64'(exp_rr[j]));
    runUntilIdle(20);

    $display("[TB] locked stream on input 1 while input 0 waits");
    pushBeat(0, {$urandom, $urandom}, 1'b1, 1'b1);
    runUntilIdle(20);
    obs_q.delete();
    for (int j = 0; j < 5; j++) pushBeat(1, {$urandom, $urandom}, 1'b1, (j == 4));
    pushBeat(0, {$urandom, $urandom}, 1'b1, 1'b1);
    runUntilIdle(40);
    checkOutput("lock_count", 64'(obs_q.size()), 64'(6));
    for (int j = 0; j < 6; j++)
      if (j < obs_q.size()) checkOutput("lock_tag", 64'(obs_q[j].tag), 64'(exp_lock[j]));

    $display("[TB] backpressure mid-stream on input 3");
    obs_q.delete();
    for (int j = 0; j < 4; j++) begin
      bp_data[j] = {$urandom, $urandom};
      pushBeat(3, bp_data[j], 1'b1, (j == 3));
    end
    for (int c = 0; c < 8; c++) begin
      rdy = rdy_pat[c];
      valid_en = '1;
      applyStimulus();
    end
    runUntilIdle(30);
    checkOutput("bp_count", 64'(obs_q.size()), 64'(4));
    for (int j = 0; j < 4; j++)
      if (j < obs_q.size()) begin
        checkOutput("bp_data", obs_q[j].data, bp_data[j]);
        checkOutput("bp_tag", 64'(obs_q[j].tag), 64'(3));
      end

    $display("[TB] keep filter on input 2");
    obs_q.delete();
    pushBeat(2, 64'hA5A5_0000_0000_0050, 1'b1, 1'b0);
    pushBeat(2, 64'hA5A5_0000_0000_0051, 1'b0, 1'b0);
    pushBeat(2, 64'hA5A5_0000_0000_0052, 1'b1, 1'b1);
    runUntilIdle(30);
    checkOutput("filt_count", 64'(obs_q.size()), 64'(2));
    if (obs_q.size() == 2) begin
      checkOutput("filt_d0", obs_q[0].data, 64'hA5A5_0000_0000_0050);
      checkOutput("filt_l0", 64'(obs_q[0].last), 64'(0));
      checkOutput("filt_d1", obs_q[1].data, 64'hA5A5_0000_0000_0052);
      checkOutput("filt_l1", 64'(obs_q[1].last), 64'(1));
      checkOutput("filt_tag", 64'(obs_q[1].tag), 64'(2));
    end
    obs_q.delete();
    pushBeat(2, 64'hA5A5_0000_0000_0053, 1'b1, 1'b0);
    pushBeat(2, 64'hA5A5_0000_0000_0054, 1'b0, 1'b1);
    runUntilIdle(30);
    checkOutput("close_count", 64'(obs_q.size()), 64'(2));
    if (obs_q.size() == 2) begin
      checkOutput("close_data", obs_q[1].data, 64'hA5A5_0000_0000_0054);
      checkOutput("close_keep", 64'(obs_q[1].keep), 64'(0));
      checkOutput("close_last", 64'(obs_q[1].last), 64'(1));
    end

    $display("[TB] random traffic");
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (src_q[i].size() < 2)
          pushBeat(i, {$urandom, $urandom}, ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0));
        valid_en[i] = ($urandom_range(0, 3) != 0);
      end
      rdy = ($urandom_range(0, 3) != 0);
      applyStimulus();
    end
    for (int i = 0; i < N; i++) pushBeat(i, {$urandom, $urandom}, 1'b1, 1'b1);
    runUntilIdle(400);
    checkOutput("sb_empty", 64'(exp_q.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
